exe_stage_mc: RTL and testbench

EXE_STAGE_MC -- requirements
Module: exe_stage_mc

---
 rtl/exe_stage_mc.sv | 154 +++++++++++++++
 tb/tb_exe_stage_mc.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_mc.sv
// Execute stage with ready/valid handshake: single-cycle ALU ops plus iterative shift-add MUL.
// Define EXE_STAGE_MC_DIV_EN to add iterative unsigned restoring DIV; otherwise DIV decodes as undefined.
module exe_stage_mc #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           EXE_CMD,
    input  logic [1:0]           val1_sel,
    input  logic [1:0]           val2_sel,
    input  logic [1:0]           ST_val_sel,
    input  logic [WORD_SIZE-1:0] val1,
    input  logic [WORD_SIZE-1:0] val2,
    input  logic [WORD_SIZE-1:0] ST_value_in,
    input  logic [WORD_SIZE-1:0] ALU_res_MEM,
    input  logic [WORD_SIZE-1:0] result_WB,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] ALUResult,
    output logic [WORD_SIZE-1:0] ST_value_out,
    output logic                 busy
);
    localparam int SHW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
    localparam int CW  = $clog2(WORD_SIZE + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [WORD_SIZE-1:0] a_q, b_q, acc_q;
    logic [WORD_SIZE-1:0] a_d, b_d, acc_d;
    logic [WORD_SIZE-1:0] op_a, op_b, st_fwd, alu_res;
    logic                 accept, is_mul, is_multi;

    function automatic logic [WORD_SIZE-1:0] fwd(input logic [1:0] sel,
                                                  input logic [WORD_SIZE-1:0] r,
                                                  input logic [WORD_SIZE-1:0] mem,
                                                  input logic [WORD_SIZE-1:0] wb);
        case (sel)
            2'd0:    fwd = r;
            2'd1:    fwd = mem;
            2'd2:    fwd = wb;
            default: fwd = '0;
        endcase
    endfunction

    assign op_a   = fwd(val1_sel,   val1,        ALU_res_MEM, result_WB);
    assign op_b   = fwd(val2_sel,   val2,        ALU_res_MEM, result_WB);
    assign st_fwd = fwd(ST_val_sel, ST_value_in, ALU_res_MEM, result_WB);

    assign in_ready  = rst_n && ((state_q == IDLE) || (state_q == DONE && out_ready));
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (EXE_CMD == 4'b1100);

`ifdef EXE_STAGE_MC_DIV_EN
    logic             div_q;
    logic             is_div;
    logic [WORD_SIZE:0] rem_sh;
    assign is_div   = (EXE_CMD == 4'b1101);
    assign is_multi = is_mul || is_div;
`else
    assign is_multi = is_mul;
`endif

    always_comb begin
        alu_res = '0;
        case (EXE_CMD)
            4'b0000: alu_res = op_a + op_b;
            4'b0010: alu_res = op_a - op_b;
            4'b0100: alu_res = op_a & op_b;
            4'b0101: alu_res = op_a | op_b;
            4'b0110: alu_res = ~(op_a | op_b);
            4'b0111: alu_res = op_a ^ op_b;
            4'b1000: alu_res = op_a << op_b[SHW-1:0];
            4'b1001: alu_res = op_a >> op_b[SHW-1:0];
            4'b1010: alu_res = $unsigned($signed(op_a) >>> op_b[SHW-1:0]);
            default: alu_res = '0;
        endcase
    end

    // One iteration per BUSY cycle. MUL: a_q multiplicand, b_q multiplier, acc_q product.
    // DIV: a_q divisor, b_q dividend shifting into quotient, acc_q remainder.
    always_comb begin
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        acc_d = b_q[0] ? acc_q + a_q : acc_q;
`ifdef EXE_STAGE_MC_DIV_EN
        rem_sh = {acc_q, b_q[WORD_SIZE-1]};
        if (div_q) begin
            a_d = a_q;
            if (rem_sh >= {1'b0, a_q}) begin
                acc_d = WORD_SIZE'(rem_sh - {1'b0, a_q});
                b_d   = {b_q[WORD_SIZE-2:0], 1'b1};
            end else begin
                acc_d = rem_sh[WORD_SIZE-1:0];
                b_d   = {b_q[WORD_SIZE-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            ALUResult    <= '0;
            ST_value_out <= '0;
`ifdef EXE_STAGE_MC_DIV_EN
            div_q        <= 1'b0;
`endif
        end else if (accept) begin
            ST_value_out <= st_fwd;
            if (is_multi) begin
                a_q     <= op_a;
                b_q     <= op_b;
                acc_q   <= '0;
                cnt_q   <= CW'(WORD_SIZE);
                state_q <= BUSY;
`ifdef EXE_STAGE_MC_DIV_EN
                div_q   <= is_div;
                if (is_div) begin
                    a_q <= op_b;
                    b_q <= op_a;
                end
`endif
            end else begin
                ALUResult <= alu_res;
                state_q   <= DONE;
            end
        end else if (state_q == BUSY) begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                state_q <= DONE;
`ifdef EXE_STAGE_MC_DIV_EN
                ALUResult <= div_q ? b_d : acc_d;
`else
                ALUResult <= acc_d;
`endif
            end
        end else if (state_q == DONE && out_ready) begin
            state_q <= IDLE;
        end
    end
endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc (WORD_SIZE=32): vector table for single-cycle ops,
// hand-written sequences for MUL/DIV latency, back-pressure and mid-operation reset.
module tb_exe_stage_mc;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0]   EXE_CMD;
    logic [1:0]   val1_sel, val2_sel, ST_val_sel;
    logic [W-1:0] val1, val2, ST_value_in, ALU_res_MEM, result_WB;
    logic [W-1:0] ALUResult, ST_value_out;

    int checks = 0;
    int errors = 0;

    exe_stage_mc #(.WORD_SIZE(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .EXE_CMD(EXE_CMD), .val1_sel(val1_sel), .val2_sel(val2_sel), .ST_val_sel(ST_val_sel),
        .val1(val1), .val2(val2), .ST_value_in(ST_value_in),
        .ALU_res_MEM(ALU_res_MEM), .result_WB(result_WB),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .ST_value_out(ST_value_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   cmd;
        logic [1:0]   s1, s2, ss;
        logic [W-1:0] v1, v2, st, mem, wb;
        logic [W-1:0] res, sto;
    } vec_t;

    vec_t tv[14];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [1:0] s1, input logic [1:0] s2,
                         input logic [1:0] ss, input logic [W-1:0] v1, input logic [W-1:0] v2,
                         input logic [W-1:0] st, input logic [W-1:0] mem, input logic [W-1:0] wb);
        EXE_CMD = cmd; val1_sel = s1; val2_sel = s2; ST_val_sel = ss;
        val1 = v1; val2 = v2; ST_value_in = st; ALU_res_MEM = mem; result_WB = wb;
        in_valid = 1'b1;
    endtask

    // Starts at a negedge with the stage able to accept; leaves at the negedge showing DONE.
    task automatic run_multi(input string name, input logic [3:0] cmd,
                             input logic [W-1:0] v1, input logic [W-1:0] v2, input logic [W-1:0] exp);
        drive(cmd, 2'd0, 2'd0, 2'd0, v1, v2, 32'h0, 32'h0, 32'h0);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i > 0) @(negedge clk);
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                chk({name, "_busy"}, {30'd0, busy, in_ready}, 32'd2);
                break;
            end
        end
        @(negedge clk);
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_res"}, ALUResult, exp);
    endtask

    initial begin
        tv[0]  = '{4'b0000, 2'd0, 2'd0, 2'd0, 32'd5,        32'd7,        32'hAA, 32'h0,   32'h0,  32'd12,       32'hAA};
        tv[1]  = '{4'b0010, 2'd1, 2'd2, 2'd3, 32'h0,        32'h0,        32'h0,  32'd100, 32'd1,  32'd99,       32'h0};
        tv[2]  = '{4'b0100, 2'd0, 2'd0, 2'd1, 32'hF0F01234, 32'h0FF0FF00, 32'h1,  32'h66,  32'h0,  32'h00F01200, 32'h66};
        tv[3]  = '{4'b0101, 2'd0, 2'd0, 2'd0, 32'hF0000000, 32'h0000000F, 32'h2,  32'h0,   32'h0,  32'hF000000F, 32'h2};
        tv[4]  = '{4'b0110, 2'd0, 2'd0, 2'd0, 32'hF0F0F0F0, 32'h0F0F0F00, 32'h3,  32'h0,   32'h0,  32'h0000000F, 32'h3};
        tv[5]  = '{4'b0111, 2'd0, 2'd0, 2'd0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h4,  32'h0,   32'h0,  32'hF0F00F0F, 32'h4};
        tv[6]  = '{4'b1000, 2'd0, 2'd0, 2'd0, 32'h1,        32'h24,       32'h5,  32'h0,   32'h0,  32'h10,       32'h5};
        tv[7]  = '{4'b1001, 2'd0, 2'd0, 2'd0, 32'h80000000, 32'd31,       32'h6,  32'h0,   32'h0,  32'h1,        32'h6};
        tv[8]  = '{4'b1010, 2'd0, 2'd0, 2'd0, 32'h80000000, 32'd4,        32'h7,  32'h0,   32'h0,  32'hF8000000, 32'h7};
        tv[9]  = '{4'b0000, 2'd0, 2'd0, 2'd0, 32'hFFFFFFFF, 32'd2,        32'h8,  32'h0,   32'h0,  32'h1,        32'h8};
        tv[10] = '{4'b0010, 2'd0, 2'd0, 2'd0, 32'h0,        32'h1,        32'h9,  32'h0,   32'h0,  32'hFFFFFFFF, 32'h9};
        tv[11] = '{4'b0011, 2'd0, 2'd0, 2'd0, 32'h12,       32'h34,       32'hA,  32'h0,   32'h0,  32'h0,        32'hA};
        tv[12] = '{4'b0000, 2'd3, 2'd1, 2'd2, 32'h1234,     32'h0,        32'hB,  32'h55,  32'h77, 32'h55,       32'h77};
        tv[13] = '{4'b0101, 2'd2, 2'd0, 2'd3, 32'h0,        32'h100,      32'h99, 32'h0,   32'h3,  32'h103,      32'h0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(4'b0000, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_alu", ALUResult, 32'd0);
        chk("rst_st", ST_value_out, 32'd0);
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Back-to-back single-cycle ops with out_ready held high.
        for (int i = 0; i < 14; i++) begin
            drive(tv[i].cmd, tv[i].s1, tv[i].s2, tv[i].ss, tv[i].v1, tv[i].v2, tv[i].st, tv[i].mem, tv[i].wb);
            chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            @(posedge clk); @(negedge clk);
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_res", i), ALUResult, tv[i].res);
            chk($sformatf("vec%0d_st", i), ST_value_out, tv[i].sto);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_idle_valid", {31'd0, out_valid}, 32'd0);

        // MUL with inputs changing and in_valid high during BUSY, then back-pressure.
        out_ready = 1'b0;
        drive(4'b1100, 2'd0, 2'd0, 2'd0, 32'hFFFFFFFF, 32'd3, 32'h5A, 32'h0, 32'h0);
        @(posedge clk); @(negedge clk);
        drive(4'b0000, 2'd0, 2'd0, 2'd0, 32'd1, 32'd1, 32'h33, 32'h0, 32'h0);
        for (int i = 0; i < W; i++) begin
            if (i > 0) @(negedge clk);
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                chk($sformatf("mul_busy_cyc%0d", i), {29'd0, busy, in_ready, out_valid}, 32'd4);
                break;
            end
        end
        @(negedge clk);
        chk("mul_valid", {31'd0, out_valid}, 32'd1);
        chk("mul_res", ALUResult, 32'hFFFFFFFD);
        chk("mul_st", ST_value_out, 32'h5A);
        chk("mul_hold_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_res", i), ALUResult, 32'hFFFFFFFD);
            chk($sformatf("hold%0d_st", i), ST_value_out, 32'h5A);
        end
        out_ready = 1'b1;
        #1 chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_res", ALUResult, 32'd2);
        chk("b2b_st", ST_value_out, 32'h33);
        in_valid = 1'b0;
        @(negedge clk);

`ifdef EXE_STAGE_MC_DIV_EN
        run_multi("div_100_7", 4'b1101, 32'd100, 32'd7, 32'd14);
        @(negedge clk);
        run_multi("div_by_0", 4'b1101, 32'd5, 32'd0, 32'hFFFFFFFF);
        @(negedge clk);
`else
        drive(4'b1101, 2'd0, 2'd0, 2'd0, 32'd100, 32'd7, 32'h0, 32'h0, 32'h0);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("div_undef_valid", {31'd0, out_valid}, 32'd1);
        chk("div_undef_res", ALUResult, 32'd0);
        @(negedge clk);
`endif
        run_multi("mul_7_9", 4'b1100, 32'd7, 32'd9, 32'd63);
        @(negedge clk);

        // Reset asserted in the tenth BUSY cycle of a MUL.
        drive(4'b1100, 2'd0, 2'd0, 2'd0, 32'd7, 32'd9, 32'h44, 32'h0, 32'h0);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_alu", ALUResult, 32'd0);
        chk("mid_rst_st", ST_value_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        drive(4'b0000, 2'd0, 2'd0, 2'd0, 32'd2, 32'd3, 32'h0, 32'h0, 32'h0);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("post_rst_add_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_add_res", ALUResult, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
